// File: rtl/write_through_buffer_pkg.sv
// Shared cache package for the write-through buffer.
// Holds default widths, the drain FSM state encoding and the buffered
// store record used by write_through_buffer and wtb_fifo_mem.
package write_through_buffer_pkg;

    localparam int WTB_ADDR_WIDTH = 10;
    localparam int WTB_DATA_WIDTH = 32;
    localparam int WTB_DEPTH      = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wtb_state_t;

    // One buffered store at the default widths.
    // wtb_fifo_mem builds a record with the same fields at its configured widths.
    typedef struct packed {
        logic [WTB_ADDR_WIDTH-1:0] addr;
        logic [WTB_DATA_WIDTH-1:0] data;
    } wtb_entry_t;

endpackage

// File: rtl/wtb_fifo_mem.sv
// Storage array and circular pointer logic for the write-through buffer.
// Pushes go in at wr_ptr and pops retire the head at rd_ptr.
// count tracks occupancy, and the caller guarantees that it never overflows
// or underflows.
// With WTB_FORWARD_EN defined, the raw entry array is exported so that the
// top module can search it for a read-miss address.
module wtb_fifo_mem
    import write_through_buffer_pkg::*;
#(
    parameter int address_width = WTB_ADDR_WIDTH,
    parameter int WIDTH         = WTB_DATA_WIDTH,
    parameter int DEPTH         = WTB_DEPTH,
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int CNT_W        = PTR_W + 1
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [address_width-1:0] push_addr,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [address_width-1:0] head_addr,
    output logic [WIDTH-1:0]         head_data,
    output logic [address_width-1:0] next_addr,
    output logic [WIDTH-1:0]         next_data,
    output logic [CNT_W-1:0]         count,
    output logic [PTR_W-1:0]         rd_ptr
`ifdef WTB_FORWARD_EN
   ,output logic [address_width-1:0] entry_addr [DEPTH],
    output logic [WIDTH-1:0]         entry_data [DEPTH]
`endif
);

    // Same fields as wtb_entry_t, sized to this instance.
    typedef struct packed {
        logic [address_width-1:0] addr;
        logic [WIDTH-1:0]         data;
    } entry_t;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] wr_next;

    assign wr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + ONE_PTR;
    assign rd_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + ONE_PTR;

    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;
    assign next_addr = mem[rd_next].addr;
    assign next_data = mem[rd_next].data;

    // The entry array has no reset.
    // A slot is only read once count says that it holds a store.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: push_addr, data: push_data};
        end
    end

    // Pointer and occupancy bookkeeping.
    // A simultaneous push and pop moves both pointers and leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_next;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

`ifdef WTB_FORWARD_EN
    // Expose every slot so the top module can search for a read-miss address.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
            entry_data[i] = mem[i].data;
        end
    end
`endif

endmodule

// File: rtl/write_through_buffer.sv
// Write-through store buffer that sits between a cache controller and main memory.
// Stores are queued in wtb_fifo_mem and drained in order by a two-state FSM.
// The head store stays counted, and therefore searchable, until memory acks it.
// Optional feature: define WTB_FORWARD_EN to forward buffered data to read misses.
// Without it, rd_hit and rd_data are tied to zero.
module write_through_buffer
    import write_through_buffer_pkg::*;
#(
    parameter int address_width = WTB_ADDR_WIDTH,
    parameter int WIDTH         = WTB_DATA_WIDTH,
    parameter int DEPTH         = WTB_DEPTH
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [address_width-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_full,
    output logic                     empty,
    input  logic [address_width-1:0] rd_addr,
    output logic                     rd_hit,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     mem_wr_req,
    output logic [address_width-1:0] mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic                     mem_wr_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wtb_state_t               state;
    logic                     push;
    logic                     pop;
    logic [CNT_W-1:0]         count;
    logic [PTR_W-1:0]         rd_ptr;
    logic [address_width-1:0] head_addr;
    logic [WIDTH-1:0]         head_data;
    logic [address_width-1:0] next_addr;
    logic [WIDTH-1:0]         next_data;
`ifdef WTB_FORWARD_EN
    logic [address_width-1:0] entry_addr [DEPTH];
    logic [WIDTH-1:0]         entry_data [DEPTH];
`endif

    // A full buffer rejects a push even when an ack frees a slot on the same edge.
    assign wr_full = (count == CNT_W'(DEPTH));
    assign push    = wr_req && !wr_full;
    assign pop     = (state == WRITE) && mem_wr_ack;
    assign empty   = (count == '0) && (state == IDLE);

    wtb_fifo_mem #(
        .address_width (address_width),
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_addr  (wr_addr),
        .push_data  (wr_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .next_addr  (next_addr),
        .next_data  (next_data),
        .count      (count),
        .rd_ptr     (rd_ptr)
`ifdef WTB_FORWARD_EN
       ,.entry_addr (entry_addr),
        .entry_data (entry_data)
`endif
    );

    // Drain FSM that presents one store at a time to memory and holds it until acked.
    // On an ack, the store behind the head is loaded immediately, so there is no idle bubble.
    // If the only store behind the head is being pushed on this edge, it is taken directly from the write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state      <= WRITE;
                        mem_wr_req <= 1'b1;
                        mem_addr   <= head_addr;
                        mem_wdata  <= head_data;
                    end
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        if (count > CNT_W'(1)) begin
                            mem_addr  <= next_addr;
                            mem_wdata <= next_data;
                        end else if (push) begin
                            mem_addr  <= wr_addr;
                            mem_wdata <= wr_data;
                        end else begin
                            state      <= IDLE;
                            mem_wr_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_wr_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef WTB_FORWARD_EN
    // Search the live entries from oldest to youngest.
    // A later match overrides an earlier one, so the youngest store wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (entry_addr[idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = entry_data[idx];
            end
        end
    end
`else
    logic unused_fwd;

    // Without forwarding, the cache controller waits for empty before a read miss.
    assign rd_hit     = 1'b0;
    assign rd_data    = '0;
    assign unused_fwd = ^{rd_addr, rd_ptr};
`endif

endmodule

// File: tb/tb_write_through_buffer.sv
// Directed self-checking bench for write_through_buffer.
// Inputs change 1ns after a rising edge, and outputs are checked in that same window.
module tb_write_through_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        empty;
    logic [9:0]  rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic        mem_wr_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_ack;

    int errors = 0;
    int checks = 0;

    write_through_buffer #(
        .address_width (10),
        .WIDTH         (32),
        .DEPTH         (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .empty      (empty),
        .rd_addr    (rd_addr),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_ack (mem_wr_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; mem_wr_ack = 1'b0;
        tick();
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr_req got=%b exp=0", mem_wr_req); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_full got=%b exp=0", wr_full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_hit got=%b exp=0", rd_hit); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (mem_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        wr_addr = 10'h005; wr_data = 32'd7; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_early got=%b exp=0", mem_wr_req); end
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL single_not_empty got=%b exp=0", empty); end
        tick();
        checks++; if (mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL single_req got=%b exp=1", mem_wr_req); end
        checks++; if (mem_addr !== 10'h005) begin errors++; $display("[TB] FAIL single_addr got=%h exp=005", mem_addr); end
        checks++; if (mem_wdata !== 32'd7) begin errors++; $display("[TB] FAIL single_data got=%0d exp=7", mem_wdata); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL single_hold_req cycle=%0d got=%b exp=1", i, mem_wr_req); end
            checks++; if (mem_addr !== 10'h005) begin errors++; $display("[TB] FAIL single_hold_addr cycle=%0d got=%h exp=005", i, mem_addr); end
            checks++; if (mem_wdata !== 32'd7) begin errors++; $display("[TB] FAIL single_hold_data cycle=%0d got=%0d exp=7", i, mem_wdata); end
        end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty_after_ack got=%b exp=1", empty); end
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_after_ack got=%b exp=0", mem_wr_req); end
    endtask

    task automatic test_fill_and_drop();
        for (int i = 1; i <= 4; i++) begin
            wr_addr = 10'h100 + 10'(i); wr_data = 32'(i); wr_req = 1'b1;
            tick();
        end
        checks++; if (wr_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got=%b exp=1", wr_full); end
        wr_addr = 10'h3FF; wr_data = 32'd99;
        tick();
        wr_req = 1'b0;
        checks++; if (dut.count !== 3'd4) begin errors++; $display("[TB] FAIL fill_drop_count got=%0d exp=4", dut.count); end
        checks++; if (wr_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_drop_full got=%b exp=1", wr_full); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL fill_drain_req idx=%0d got=%b exp=1", i, mem_wr_req); end
            checks++; if (mem_wdata !== 32'(i)) begin errors++; $display("[TB] FAIL fill_drain_data got=%0d exp=%0d", mem_wdata, i); end
            checks++; if (mem_addr !== 10'h100 + 10'(i)) begin errors++; $display("[TB] FAIL fill_drain_addr got=%h exp=%h", mem_addr, 10'h100 + 10'(i)); end
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fill_empty got=%b exp=1", empty); end
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_dropped_write got=%b exp=0", mem_wr_req); end
    endtask

    task automatic test_full_push_ack();
        for (int i = 11; i <= 14; i++) begin
            wr_addr = 10'h200 + 10'(i); wr_data = 32'(i); wr_req = 1'b1;
            tick();
        end
        wr_req = 1'b0;
        checks++; if (wr_full !== 1'b1) begin errors++; $display("[TB] FAIL fpa_full got=%b exp=1", wr_full); end
        wr_addr = 10'h277; wr_data = 32'd77; wr_req = 1'b1; mem_wr_ack = 1'b1;
        tick();
        wr_req = 1'b0; mem_wr_ack = 1'b0;
        checks++; if (dut.count !== 3'd3) begin errors++; $display("[TB] FAIL fpa_count got=%0d exp=3", dut.count); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("[TB] FAIL fpa_not_full got=%b exp=0", wr_full); end
        for (int i = 12; i <= 14; i++) begin
            checks++; if (mem_wdata !== 32'(i)) begin errors++; $display("[TB] FAIL fpa_drain_data got=%0d exp=%0d", mem_wdata, i); end
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fpa_empty got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        wr_addr = 10'h0AA; wr_data = 32'h55; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        checks++; if (mem_wdata !== 32'h55) begin errors++; $display("[TB] FAIL b2b_first_data got=%h exp=55", mem_wdata); end
        wr_addr = 10'h0BB; wr_data = 32'h66; wr_req = 1'b1; mem_wr_ack = 1'b1;
        tick();
        wr_req = 1'b0; mem_wr_ack = 1'b0;
        checks++; if (mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req got=%b exp=1", mem_wr_req); end
        checks++; if (mem_wdata !== 32'h66) begin errors++; $display("[TB] FAIL b2b_second_data got=%h exp=66", mem_wdata); end
        checks++; if (mem_addr !== 10'h0BB) begin errors++; $display("[TB] FAIL b2b_second_addr got=%h exp=0bb", mem_addr); end
        checks++; if (dut.count !== 3'd1) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=1", dut.count); end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_forwarding();
`ifdef WTB_FORWARD_EN
        wr_addr = 10'h020; wr_data = 32'd5; wr_req = 1'b1;
        tick();
        wr_data = 32'd6;
        tick();
        wr_req = 1'b0;
        rd_addr = 10'h020;
        #1;
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("[TB] FAIL fwd_hit got=%b exp=1", rd_hit); end
        checks++; if (rd_data !== 32'd6) begin errors++; $display("[TB] FAIL fwd_youngest got=%0d exp=6", rd_data); end
        rd_addr = 10'h021;
        #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd_miss got=%b exp=0", rd_hit); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("[TB] FAIL fwd_miss_data got=%0d exp=0", rd_data); end
        rd_addr = 10'h020;
        for (int i = 5; i <= 6; i++) begin
            checks++; if (mem_wdata !== 32'(i)) begin errors++; $display("[TB] FAIL fwd_drain_data got=%0d exp=%0d", mem_wdata, i); end
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
        end
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd_hit_after_drain got=%b exp=0", rd_hit); end
`else
        wr_addr = 10'h020; wr_data = 32'd5; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        rd_addr = 10'h020;
        #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("[TB] FAIL nofwd_hit got=%b exp=0", rd_hit); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("[TB] FAIL nofwd_data got=%0d exp=0", rd_data); end
        tick();
        checks++; if (mem_wdata !== 32'd5) begin errors++; $display("[TB] FAIL nofwd_drain_data got=%0d exp=5", mem_wdata); end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
`endif
        rd_addr = '0;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fwd_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < 3; i++) begin
            wr_addr = 10'h300 + 10'(i); wr_data = 32'd30 + 32'(i); wr_req = 1'b1;
            tick();
        end
        wr_req = 1'b0;
        tick();
        checks++; if (mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL rmw_in_write got=%b exp=1", mem_wr_req); end
        reset = 1'b1;
        #1;
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("[TB] FAIL rmw_req_cleared got=%b exp=0", mem_wr_req); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rmw_empty got=%b exp=1", empty); end
        checks++; if (mem_addr !== 10'd0) begin errors++; $display("[TB] FAIL rmw_addr got=%h exp=0", mem_addr); end
        tick();
        reset = 1'b0;
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        checks++; if (dut.count !== 3'd0) begin errors++; $display("[TB] FAIL rmw_late_ack_count got=%0d exp=0", dut.count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rmw_late_ack_empty got=%b exp=1", empty); end
        tick();
        checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("[TB] FAIL rmw_no_restart got=%b exp=0", mem_wr_req); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) begin
            wr_addr = 10'h040 + 10'(i); wr_data = 32'd200 + 32'(i); wr_req = 1'b1;
            tick();
            wr_req = 1'b0;
            tick();
            checks++; if (mem_wdata !== 32'd200 + 32'(i)) begin errors++; $display("[TB] FAIL wrap_data got=%0d exp=%0d", mem_wdata, 200 + i); end
            checks++; if (mem_addr !== 10'h040 + 10'(i)) begin errors++; $display("[TB] FAIL wrap_addr got=%h exp=%h", mem_addr, 10'h040 + 10'(i)); end
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
            checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty iter=%0d got=%b exp=1", i, empty); end
        end
        checks++; if (dut.u_fifo.wr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL wrap_wr_ptr got=%0d exp=2", dut.u_fifo.wr_ptr); end
        checks++; if (dut.u_fifo.rd_ptr !== 2'd2) begin errors++; $display("[TB] FAIL wrap_rd_ptr got=%0d exp=2", dut.u_fifo.rd_ptr); end
    endtask

    initial begin
        $display("[TB] write_through_buffer directed bench starting");
        test_reset();
        test_single_write();
        test_fill_and_drop();
        test_full_push_ack();
        test_back_to_back();
        test_forwarding();
        test_reset_mid_write();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_through_buffer.md
WRITE_THROUGH_BUFFER -- requirements
Module: write_through_buffer

Interface
REQ-001 SHALL have parameter address_width, default 10, meaning word-address width.
REQ-002 SHALL have parameter WIDTH, default 32, meaning data-word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning entry count, power of two, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_req  input  1  cache controller pushes one write-through store.
REQ-007 SHALL have port wr_addr  input  address_width  store word address.
REQ-008 SHALL have port wr_data  input  WIDTH  store data.
REQ-009 SHALL have port wr_full  output  1  buffer full; the cache controller stalls on it.
REQ-010 SHALL have port empty  output  1  no valid entries and no write in flight.
REQ-011 SHALL have port rd_addr  input  address_width  read-miss address probed for forwarding.
REQ-012 SHALL have port rd_hit  output  1  rd_addr matches a buffered entry.
REQ-013 SHALL have port rd_data  output  WIDTH  data of the youngest matching entry.
REQ-014 SHALL have port mem_wr_req  output  1  write request to main memory.
REQ-015 SHALL have port mem_addr  output  address_width  memory write address.
REQ-016 SHALL have port mem_wdata  output  WIDTH  memory write data.
REQ-017 SHALL have port mem_wr_ack  input  1  one-cycle pulse from memory; write complete.

Function
REQ-018 SHALL be a circular FIFO: wr_ptr, rd_ptr, count of width log2(DEPTH)+1; pointers wrap DEPTH-1 -> 0.
REQ-019 SHALL accept a push on a rising edge with wr_req=1 and wr_full=0; a push while wr_full=1 is dropped with no state change.
REQ-020 SHALL drive wr_full = (count==DEPTH) combinationally; a same-cycle ack does not admit a push into a full buffer.
REQ-021 SHALL run a drain FSM with states IDLE and WRITE.
REQ-022 SHALL transition from IDLE to WRITE on the first edge where count>0, latching the head entry into mem_addr/mem_wdata.
REQ-023 SHALL hold mem_wr_req=1 and mem_addr/mem_wdata stable throughout WRITE.
REQ-024 SHALL, on mem_wr_ack in WRITE, pop the head (count-1, rd_ptr+1); then go to WRITE with the next entry if count after pop >0, else IDLE, with no idle bubble.
REQ-025 SHALL ignore mem_wr_ack in IDLE.
REQ-026 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-027 SHALL keep the head entry counted in count until it is acked, so the head stays forwardable.
REQ-028 SHALL drive empty = (count==0) and (state==IDLE).
REQ-029 SHALL preserve store order to memory exactly as pushed; no coalescing.

Reset
REQ-030 SHALL, on reset=1, immediately clear count, wr_ptr, rd_ptr, set state IDLE, and drive mem_wr_req=0, wr_full=0, empty=1, rd_hit=0, rd_data=0, mem_addr=0, mem_wdata=0.
REQ-031 SHALL discard buffered and in-flight writes on reset asserted mid-WRITE; an ack arriving after reset is ignored.
REQ-032 SHALL NOT require reset to clear the entry data array.

Configuration
REQ-033 SHALL, with WTB_FORWARD_EN defined, compare rd_addr combinationally against all valid entries and drive rd_hit=1 and rd_data from the youngest match.
REQ-034 SHALL, without WTB_FORWARD_EN, tie rd_hit=0 and rd_data=0; the cache controller then waits for empty=1 before issuing a read miss.

Structure
REQ-035 SHALL take address_width/WIDTH defaults, the FSM state enumeration and the entry record (addr, data) from the shared cache package.
REQ-036 SHALL keep the storage array and pointer logic in one sub-module, wtb_fifo_mem; the FSM and forwarding stay in the top module.

Verification
REQ-037 SHALL cover: reset, then push (addr 10'h005, data 7) -> mem_wr_req=1 next cycle with addr 10'h005/data 7; hold ack off 3 cycles, address and data stable; after ack, empty=1.
REQ-038 SHALL cover: 4 pushes with no ack -> wr_full=1; a 5th push (data 99) is dropped; acks drain data in push order 1,2,3,4.
REQ-039 SHALL cover: full buffer with push and ack in the same cycle -> push rejected, count=3.
REQ-040 SHALL cover, with WTB_FORWARD_EN: push (10'h020, 5) then (10'h020, 6); rd_addr=10'h020 -> rd_hit=1, rd_data=6; rd_addr=10'h021 -> rd_hit=0.
REQ-041 SHALL cover: reset asserted mid-WRITE with 3 entries -> mem_wr_req=0 immediately, empty=1; a late ack causes no pop.
REQ-042 SHALL cover: 6 push/ack cycles -> pointers wrap past DEPTH-1 and the data order is correct.
